// File: rtl/inverse_fir_equalizer_pkg.sv
// Shared constants, FSM encoding and the round/saturate helper for the
// inverse-channel FIR equalizer. Q2.13 data, 37-bit accumulator.
// Pure package: no latency, no flow control.
package inverse_fir_equalizer_pkg;

  localparam int TAPS = 31;
  localparam int DW   = 16;
  localparam int FRAC = 13;
  localparam int ACCW = 37;
  localparam int AW   = $clog2(TAPS);

  localparam logic [DW-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DW-1:0] Q_MIN = 16'h8000;

  // Accumulator-width images of the Q2.13 limits and the rounding half-LSB.
  localparam logic signed [ACCW-1:0] SAT_HI   = {{(ACCW-DW){1'b0}}, Q_MAX};
  localparam logic signed [ACCW-1:0] SAT_LO   = {{(ACCW-DW){1'b1}}, Q_MIN};
  localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(1 << (FRAC-1));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_ROUND,
    ST_HOLD
  } state_t;

  // Q4.26 accumulator -> Q2.13: add half an output LSB, arithmetic shift
  // (so exact ties move toward +inf), then clamp to the 16-bit range.
  function automatic logic [DW-1:0] round_sat(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] r;
    r = (a + RND_HALF) >>> FRAC;
    if (r > SAT_HI) begin
      return Q_MAX;
    end else if (r < SAT_LO) begin
      return Q_MIN;
    end
    return r[DW-1:0];
  endfunction

endpackage

// File: rtl/inverse_fir_delay_line.sv
// 31-entry circular sample buffer: one write port, one tap-indexed read port.
// Write takes effect at the edge; read is combinational from tap and wr_ptr.
// No backpressure: the caller decides when wr_en fires.
// Ports: clk, rst_n (sync, active low), flush (sync clear), wr_en/wr_data,
//        tap (k = 0 is the newest sample), rd_data (x[n-k]).
module inverse_fir_delay_line
  import inverse_fir_equalizer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] tap,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [TAPS];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] newest;
  logic [AW-1:0] rd_idx;

  always_comb begin
    newest = (wr_ptr == '0) ? AW'(TAPS-1) : wr_ptr - 1'b1;
    // (newest - tap) mod 31; the wrapped branch result is always <= 30,
    // so the 5-bit arithmetic cannot alias.
    rd_idx = (newest >= tap) ? newest - tap : newest + AW'(TAPS) - tap;
    rd_data = mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      for (int i = 0; i < TAPS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= (wr_ptr == AW'(TAPS-1)) ? '0 : wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/inverse_fir_equalizer.sv
// 31-tap inverse-channel FIR equalizer, single time-multiplexed MAC, Q2.13.
// One sample per pass: 31 MAC cycles + 1 round cycle, result held until taken.
// in_ready low from accept until the output handshake; out_sample stable under stall.
// Ports: clk, rst_n (sync, active low), flush (sync clear/abort),
//        in_valid/in_ready/in_sample, coef_addr -> coef_data (external table,
//        combinational), out_valid/out_ready/out_sample.
module inverse_fir_equalizer
  import inverse_fir_equalizer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sample,
  output logic [AW-1:0] coef_addr,
  input  logic [DW-1:0] coef_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_sample
);

  state_t state_q, state_d;

  logic                   accept;
  logic                   last_tap;
  logic [DW-1:0]          tap_data;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc;

  inverse_fir_delay_line u_dline (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (accept),
    .wr_data (in_sample),
    .tap     (coef_addr),
    .rd_data (tap_data)
  );

  assign prod     = $signed(tap_data) * $signed(coef_data);
  assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
  assign last_tap = (coef_addr == AW'(TAPS-1));

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == ST_IDLE);
    // flush wins over a same-cycle input handshake: the sample is dropped.
    accept   = in_valid && in_ready && !flush;
    case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_MAC;
      ST_MAC:   if (last_tap)  state_d = ST_ROUND;
      ST_ROUND:                state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      coef_addr  <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else if (flush) begin
      acc       <= '0;
      coef_addr <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            acc       <= '0;
            coef_addr <= '0;
          end
        end
        ST_MAC: begin
          acc       <= acc + prod_ext;
          coef_addr <= last_tap ? '0 : coef_addr + 1'b1;
        end
        ST_ROUND: begin
          out_sample <= round_sat(acc);
          out_valid  <= 1'b1;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_fir_equalizer.sv
module tb_inverse_fir_equalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sample;
  logic [4:0]  coef_addr;
  logic [15:0] coef_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sample;

  logic [15:0] coef  [0:30];
  logic [15:0] htrue [0:30];
  logic [15:0] hhalf [0:15];
  int          hist  [0:30];   // hist[k] = x[n-k], sign-extended
  int          checks = 0;
  int          errors = 0;

  inverse_fir_equalizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample)
  );

  always #5 clk = ~clk;

  assign coef_data = coef[coef_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int k = 0; k < 31; k++) hist[k] = 0;
  endtask

  // Reference: y = sat(floor((sum x[n-k]*h[k] + 2^12) / 2^13)).
  function automatic logic [15:0] model_out();
    longint acc = 0;
    longint q;
    longint r;
    for (int k = 0; k < 31; k++)
      acc += longint'(hist[k]) * longint'($signed(coef[k]));
    q = acc + 4096;
    r = (q >= 0) ? q / 8192 : -((-q + 8191) / 8192);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    clear_hist();
  endtask

  task automatic push(input logic [15:0] s);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_sample = s;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 30; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'($signed(s));
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check("out_valid_wait", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic push_get(input logic [15:0] s, input string tag, input int stall,
                          output logic [15:0] got);
    logic [15:0] exp;
    push(s);
    exp = model_out();
    wait_out();
    repeat (stall) @(negedge clk);
    check(tag, {16'd0, out_sample}, {16'd0, exp});
    got = out_sample;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic impulse_run(input string tag);
    logic [15:0] got;
    for (int i = 0; i < 31; i++) begin
      push_get((i == 0) ? 16'h2000 : 16'h0000, tag, 0, got);
      check({tag, "_h"}, {16'd0, got}, {16'd0, htrue[i]});
    end
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] held;
    int t0, t1, n;

    hhalf = '{16'hFFD2, 16'hFFFA, 16'h0045, 16'hFFC0, 16'h0071, 16'hFF90,
              16'h00B2, 16'hFF2A, 16'h0120, 16'hFE6C, 16'h0236, 16'hFD10,
              16'h0410, 16'hF9E0, 16'h0A40, 16'h0B40};
    for (int i = 0; i < 16; i++) htrue[i] = hhalf[i];
    for (int i = 16; i < 31; i++) htrue[i] = htrue[30-i];
    for (int i = 0; i < 31; i++) coef[i] = htrue[i];
    clear_hist();

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",   {31'd0, in_ready},  32'd1);
    check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_out_sample", {16'd0, out_sample}, 32'd0);
    check("rst_coef_addr",  {27'd0, coef_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse with the true inverse-channel table.
    impulse_run("impulse");

    // Throughput with out_ready and in_valid held high.
    do_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_sample = '0;
    t0 = -1; t1 = -1;
    for (int c = 0; c < 200 && t1 < 0; c++) begin
      if (in_ready) begin
        if (t0 < 0) t0 = c; else t1 = c;
      end
      @(negedge clk);
    end
    check("period", 32'(t1 - t0), 32'd34);
    in_valid = 1'b0; out_ready = 1'b0;
    do_flush();

    // Rounding: h[0] = 0.5 only.
    for (int i = 0; i < 31; i++) coef[i] = 16'h0000;
    coef[0] = 16'h1000;
    push_get(16'h0001, "round_pos", 0, got);
    check("round_pos_const", {16'd0, got}, 32'h0001);
    push_get(16'hFFFF, "round_tie", 0, got);
    check("round_tie_const", {16'd0, got}, 32'h0000);

    // Saturation.
    do_flush();
    for (int i = 0; i < 31; i++) coef[i] = 16'h7FFF;
    for (int i = 0; i < 31; i++) push_get(16'h7FFF, "sat_pos", 0, got);
    check("sat_pos_const", {16'd0, got}, 32'h7FFF);
    for (int i = 0; i < 31; i++) push_get(16'h8000, "sat_neg", 0, got);
    check("sat_neg_const", {16'd0, got}, 32'h8000);

    // Backpressure: result held, input blocked, ready one cycle after release.
    for (int i = 0; i < 31; i++) coef[i] = htrue[i];
    push(16'h1234);
    held = model_out();
    wait_out();
    for (int i = 0; i < 10; i++) begin
      check("bp_hold",     {16'd0, out_sample}, {16'd0, held});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_ready", {31'd0, in_ready},  32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);

    // Randomized coefficients, samples and output stalls.
    for (int i = 0; i < 31; i++)
      coef[i] = (i % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
    for (int i = 0; i < 40; i++)
      push_get(16'($urandom), "random", int'($urandom_range(0, 3)), got);

    // Reset in the middle of a pass.
    for (int i = 0; i < 31; i++) coef[i] = htrue[i];
    push(16'h3FFF);
    n = 0;
    while (coef_addr != 5'd12 && n < 100) begin @(negedge clk); n++; end
    check("midmac_reach", {27'd0, coef_addr}, 32'd12);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_hist();
    check("midmac_out_valid", {31'd0, out_valid}, 32'd0);
    check("midmac_in_ready",  {31'd0, in_ready},  32'd1);
    check("midmac_coef_addr", {27'd0, coef_addr}, 32'd0);
    impulse_run("post_reset");

    // flush coinciding with an input handshake drops the sample.
    push(16'h4000);
    wait_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_sample = 16'h4000; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    clear_hist();
    check("flush_in_ready",  {31'd0, in_ready},  32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_no_result", {31'd0, out_valid}, 32'd0);
    impulse_run("post_flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
